islip_pointer_ctrl: RTL
=======================

ISLIP_POINTER_CTRL -- requirements
Module: islip_pointer_ctrl

Interface
REQ-001 Parameter N, default 32, number of ports / width of the pointer and grant vectors (N >= 2).
REQ-002 Parameter W, default $clog2(N), width of the binary grant index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_grant  input  N  grant vector from the programmable priority encoder; expected one-hot or zero.
REQ-006 in_grant_valid  input  1  in_grant is valid this cycle.
REQ-007 in_first_iter  input  1  the current grant belongs to iSLIP iteration 1; sampled with in_grant_valid.
REQ-008 in_acc_valid  input  1  accept result is valid this cycle.
REQ-009 in_accept  input  1  the granted port accepted (1) or declined (0); meaningful only with in_acc_valid.
REQ-010 out_p_enc  output  N  one-hot round-robin pointer that drives the encoder's in_p_enc.
REQ-011 out_idx  output  W  binary index of the latched grant.
REQ-012 out_idx_valid  output  1  out_idx holds a latched grant awaiting an accept result.
REQ-013 out_busy  output  1  block is in WAIT_ACC and ignores new grants.
REQ-014 out_err  output  1  one-cycle pulse: multi-hot in_grant rejected.

Function
REQ-015 FSM states: IDLE, WAIT_ACC; all outputs registered.
REQ-016 IDLE, in_grant_valid=1 and in_grant one-hot: latch the grant, the index and in_first_iter; out_idx <= index; out_idx_valid <= 1; out_busy <= 1; next state WAIT_ACC.
REQ-017 IDLE, in_grant_valid=1 and in_grant all-zero: no state change, no error.
REQ-018 IDLE, in_grant_valid=1 and in_grant has >=2 bits set: out_err = 1 for exactly the next cycle; grant discarded; state stays IDLE; pointer unchanged.
REQ-019 Index encoding: out_idx = position of the single set bit (bit 0 -> 0, bit N-1 -> N-1).
REQ-020 WAIT_ACC, in_acc_valid=1: next state IDLE; out_idx_valid <= 0; out_busy <= 0; out_idx holds its last value.
REQ-021 Pointer update happens only on that WAIT_ACC transition, and only when in_accept=1 and the latched first-iter flag = 1; then out_p_enc <= one-hot at (latched index + 1) mod N.
REQ-022 Wrap-around: latched index N-1 accepted -> out_p_enc = one-hot bit 0.
REQ-023 A decline (in_accept=0), or an accept in a non-first iteration, leaves out_p_enc unchanged.
REQ-024 WAIT_ACC: in_grant_valid is ignored; no latch and no error pulse, even when the grant is multi-hot.
REQ-025 WAIT_ACC, in_acc_valid=0: hold all state indefinitely; no timeout.
REQ-026 IDLE: in_acc_valid is ignored.
REQ-027 Latency: grant sampled in cycle t -> out_idx_valid high in cycle t+1; accept sampled in cycle t -> updated out_p_enc visible in cycle t+1.
REQ-028 out_p_enc is exactly one-hot at all times after reset.

Reset
REQ-029 rst_n=0 sampled on a clock edge: state IDLE; out_p_enc = one-hot bit 0; out_idx = 0; out_idx_valid = 0; out_busy = 0; out_err = 0; latched grant and first-iter flag = 0.
REQ-030 Reset asserted in WAIT_ACC: a pending grant is dropped with no pointer update; reset takes priority over every simultaneous input.
REQ-031 Reset acts only on clock edges; an rst_n pulse between edges has no effect.

Verification
REQ-032 Reset, then grant 0x0000_0010 with first_iter=1 -> out_idx=4, out_idx_valid=1; then accept=1 -> out_p_enc=0x0000_0020, out_idx_valid=0.
REQ-033 Grant 0x8000_0000 with first_iter=1, accept=1 -> out_p_enc=0x0000_0001 (wrap).
REQ-034 Grant 0x0000_0100 with first_iter=0, accept=1 -> out_p_enc unchanged; grant 0x0000_0100 with first_iter=1, accept=0 -> out_p_enc unchanged.
REQ-035 Grant 0x0000_0003 in IDLE -> out_err pulses for 1 cycle, state IDLE. A 0x0000_0003 grant presented in WAIT_ACC -> no out_err.
REQ-036 Grant 0x0000_0004, hold 5 cycles with no acc_valid, then rst_n=0 -> out_p_enc=0x0000_0001 and all valid/busy flags are 0 in the next cycle.
REQ-037 Random one-hot/zero/multi-hot stream against a reference model -> out_p_enc stays one-hot and matches the model every cycle.

Source files
------------

// File: rtl/islip_pointer_ctrl.sv
// iSLIP grant pointer control: latch a one-hot grant, await accept, advance round-robin pointer.
// Latency 1 cycle grant->out_idx_valid and accept->out_p_enc; new grants ignored while busy.
module islip_pointer_ctrl #(
   parameter int N = 32,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_grant,
   input  logic         in_grant_valid,
   input  logic         in_first_iter,
   input  logic         in_acc_valid,
   input  logic         in_accept,
   output logic [N-1:0] out_p_enc,
   output logic [W-1:0] out_idx,
   output logic         out_idx_valid,
   output logic         out_busy,
   output logic         out_err
);

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_ACC = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   lat_grant, lat_grant_nxt;
   logic           lat_first, lat_first_nxt;
   logic [N-1:0]   ptr_nxt;
   logic [W-1:0]   idx_nxt;
   logic           idx_valid_nxt, busy_nxt, err_nxt;

   logic           grant_any, grant_multi, grant_onehot;
   logic [W-1:0]   grant_idx;

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign grant_any    = |in_grant;
   assign grant_multi  = |(in_grant & (in_grant - {{(N-1){1'b0}}, 1'b1}));
   assign grant_onehot = grant_any && !grant_multi;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (in_grant[i]) grant_idx = W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (in_grant_valid && grant_onehot) state_nxt = WAIT_ACC;
         WAIT_ACC: if (in_acc_valid) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ptr_nxt       = out_p_enc;
      idx_nxt       = out_idx;
      idx_valid_nxt = out_idx_valid;
      busy_nxt      = out_busy;
      err_nxt       = 1'b0;
      lat_grant_nxt = lat_grant;
      lat_first_nxt = lat_first;
      case (state)
         IDLE: begin
            if (in_grant_valid && grant_onehot) begin
               lat_grant_nxt = in_grant;
               lat_first_nxt = in_first_iter;
               idx_nxt       = grant_idx;
               idx_valid_nxt = 1'b1;
               busy_nxt      = 1'b1;
            end else if (in_grant_valid && grant_multi) begin
               err_nxt = 1'b1;
            end
         end
         WAIT_ACC: begin
            if (in_acc_valid) begin
               idx_valid_nxt = 1'b0;
               busy_nxt      = 1'b0;
               // Rotating the latched one-hot grant left gives (index + 1) mod N.
               if (in_accept && lat_first)
                  ptr_nxt = {lat_grant[N-2:0], lat_grant[N-1]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_p_enc     <= {{(N-1){1'b0}}, 1'b1};
         out_idx       <= '0;
         out_idx_valid <= 1'b0;
         out_busy      <= 1'b0;
         out_err       <= 1'b0;
         lat_grant     <= '0;
         lat_first     <= 1'b0;
      end else begin
         out_p_enc     <= ptr_nxt;
         out_idx       <= idx_nxt;
         out_idx_valid <= idx_valid_nxt;
         out_busy      <= busy_nxt;
         out_err       <= err_nxt;
         lat_grant     <= lat_grant_nxt;
         lat_first     <= lat_first_nxt;
      end
   end

endmodule
